// File: rtl/aes_dec_key_stream_pkg.sv
// Shared AES types, S-box, GF(2^8) helpers and FSM states for the decrypt-order key streamer.
package aes_pkg;

  typedef logic [0:127] block_t;
  typedef logic [0:31]  word_t;

  typedef enum logic [1:0] {StIdle, StExpand, StStream, StDone} state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // Element 0 is the leftmost byte of the concatenation.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic word_t sub_word(input word_t w);
    word_t r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = SBOX[w[8*i +: 8]];
    end
    return r;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic word_t inv_mix_column(input word_t c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[0:7];
    a1 = c[8:15];
    a2 = c[16:23];
    a3 = c[24:31];
    return {gf_mul(a0, 4'd14) ^ gf_mul(a1, 4'd11) ^ gf_mul(a2, 4'd13) ^ gf_mul(a3, 4'd9),
            gf_mul(a0, 4'd9)  ^ gf_mul(a1, 4'd14) ^ gf_mul(a2, 4'd11) ^ gf_mul(a3, 4'd13),
            gf_mul(a0, 4'd13) ^ gf_mul(a1, 4'd9)  ^ gf_mul(a2, 4'd14) ^ gf_mul(a3, 4'd11),
            gf_mul(a0, 4'd11) ^ gf_mul(a1, 4'd13) ^ gf_mul(a2, 4'd9)  ^ gf_mul(a3, 4'd14)};
  endfunction

endpackage

// File: rtl/aes_dec_key_stream_if.sv
// Start/key request and round-key stream handshake bundle for aes_dec_key_stream.
interface aes_dec_key_stream_if;
  logic           i_start;
  logic [0:127]   i_key;
  logic           o_busy;
  logic [0:127]   o_rk;
  logic [3:0]     o_rk_idx;
  logic           o_rk_valid;
  logic           i_rk_ready;
  logic           o_last;
  logic           o_done;

  modport slave (
    input  i_start, i_key, i_rk_ready,
    output o_busy, o_rk, o_rk_idx, o_rk_valid, o_last, o_done
  );

  modport master (
    output i_start, i_key, i_rk_ready,
    input  o_busy, o_rk, o_rk_idx, o_rk_valid, o_last, o_done
  );
endinterface

// File: rtl/aes_dec_key_stream_key_round.sv
// One AES-128 key-schedule step: previous round key and rcon byte to the next round key.
module aes_key_round
  import aes_pkg::*;
(
  input  block_t     prev_i,
  input  logic [7:0] rcon_i,
  output block_t     next_o
);

  word_t w0, w1, w2, w3, t, n0, n1, n2, n3;

  always_comb begin
    w0 = prev_i[0:31];
    w1 = prev_i[32:63];
    w2 = prev_i[64:95];
    w3 = prev_i[96:127];
    t  = sub_word({w3[8:31], w3[0:7]}) ^ {rcon_i, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_o = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_dec_key_stream.sv
// Expands an AES-128 key one round per cycle and streams round keys 10 down to 0.
// AES_EQ_INV_KEY_EN: beats 9..1 carry InvMixColumns(rk) for the equivalent inverse cipher.
module aes_dec_key_stream
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic                 clk,
  input  logic                 i_reset,
  aes_dec_key_stream_if.slave  bus
);

  if (NR != 10) begin : g_nr_check
    $error("aes_dec_key_stream supports only NR == 10");
  end

  state_e     state_q, state_d;
  logic [3:0] r_q, r_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] rcon_q, rcon_d;
  block_t     rk_q [0:NR];
  block_t     rk_next;
  block_t     beat_rk;
  logic       load_key, write_rk, valid, done;

  aes_key_round u_key_round (
    .prev_i (rk_q[r_q - 4'd1]),
    .rcon_i (rcon_q),
    .next_o (rk_next)
  );

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    idx_d    = idx_q;
    rcon_d   = rcon_q;
    load_key = 1'b0;
    write_rk = 1'b0;
    valid    = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.i_start) begin
          load_key = 1'b1;
          rcon_d   = RCON_INIT;
          r_d      = 4'd1;
          state_d  = StExpand;
        end
      end
      StExpand: begin
        write_rk = 1'b1;
        rcon_d   = xtime(rcon_q);
        r_d      = r_q + 4'd1;
        if (r_q == 4'(NR)) begin
          idx_d   = 4'(NR);
          state_d = StStream;
        end
      end
      StStream: begin
        valid = 1'b1;
        if (bus.i_rk_ready) begin
          if (idx_q == 4'd0) state_d = StDone;
          else               idx_d   = idx_q - 4'd1;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // r_q resets to 1 so the key-round read index never leaves 0..NR.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      r_q     <= 4'd1;
      idx_q   <= 4'd0;
      rcon_q  <= 8'h00;
      for (int i = 0; i <= NR; i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      if (load_key) rk_q[0]   <= bus.i_key;
      if (write_rk) rk_q[r_q] <= rk_next;
    end
  end

  always_comb begin
    beat_rk = rk_q[idx_q];
`ifdef AES_EQ_INV_KEY_EN
    if (idx_q != 4'd0 && idx_q != 4'(NR)) begin
      for (int w = 0; w < 4; w++) begin
        beat_rk[32*w +: 32] = inv_mix_column(rk_q[idx_q][32*w +: 32]);
      end
    end
`endif
    bus.o_rk       = valid ? beat_rk : '0;
    bus.o_rk_idx   = valid ? idx_q : 4'd0;
    bus.o_rk_valid = valid;
    bus.o_last     = valid && (idx_q == 4'd0);
    bus.o_done     = done;
    bus.o_busy     = (state_q == StExpand) || (state_q == StStream);
  end

endmodule

// File: tb/tb_aes_dec_key_stream.sv
// Randomized bench for aes_dec_key_stream against a FIPS-197 word-level key-expansion model.
module tb_aes_dec_key_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_dec_key_stream_if bus ();

  aes_dec_key_stream #(.NR(10)) dut (
    .clk     (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int beats    = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_rk [11];
  logic [127:0] got_rk [11];

  localparam logic [127:0] FipsKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsRk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FipsRk1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] ZeroRk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic init_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv;
      sbox_m[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                  ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) exp_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] m [4] = '{8'd14, 8'd11, 8'd13, 8'd9};
    logic [7:0] a [4];
    logic [31:0] o;
    for (int i = 0; i < 4; i++) a[i] = c[31 - 8*i -: 8];
    for (int r = 0; r < 4; r++) begin
      o[31 - 8*r -: 8] = 8'h00;
      for (int k = 0; k < 4; k++) o[31 - 8*r -: 8] = o[31 - 8*r -: 8] ^ gmul(m[(k-r+4)%4], a[k]);
    end
    return o;
  endfunction

  function automatic logic [127:0] beat_of(input logic [127:0] rk, input int k);
    logic [127:0] b = rk;
`ifdef AES_EQ_INV_KEY_EN
    if (k >= 1 && k <= 9) begin
      for (int c = 0; c < 4; c++) b[127 - 32*c -: 32] = inv_mix_col(rk[127 - 32*c -: 32]);
    end
`endif
    return b;
  endfunction

  task automatic run_stream(input logic [127:0] key, input bit rand_ready, input bit timing,
                            input bit busy_starts, input int abort_idx, input string name);
    int exp_idx;
    int guard;
    bit hs;
    bit prev_stall;
    logic [127:0] prev_rk;
    logic [3:0]   prev_idx;
    model_expand(key);
    beats = 0;
    for (int k = 0; k < 11; k++) got_rk[k] = '0;
    bus.i_key   = key;
    bus.i_start = 1'b1;
    cyc = 0;
    tick();
    bus.i_start = 1'b0;
    bus.i_key   = ~key;
    chk({name, "_busy_c1"}, 128'(bus.o_busy), 128'd1);
    guard = 0;
    while (bus.o_rk_valid !== 1'b1 && guard < 40) begin
      bus.i_rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (busy_starts && cyc == 3) begin
        bus.i_start = 1'b1;
        bus.i_key   = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        bus.i_start = 1'b0;
      end
      tick();
      guard++;
    end
    bus.i_start = 1'b0;
    chk({name, "_first_valid"}, 128'(bus.o_rk_valid), 128'd1);
    if (timing) chk({name, "_first_valid_cycle"}, 128'(cyc), 128'd11);
    exp_idx = 10;
    prev_stall = 1'b0;
    prev_rk = '0;
    prev_idx = '0;
    guard = 0;
    while (guard < 200) begin
      if (prev_stall) begin
        chk({name, "_stall_rk"}, bus.o_rk, prev_rk);
        chk({name, "_stall_idx"}, 128'(bus.o_rk_idx), 128'(prev_idx));
      end
      chk({name, "_valid"}, 128'(bus.o_rk_valid), 128'd1);
      chk({name, "_idx"}, 128'(bus.o_rk_idx), 128'(exp_idx));
      chk({name, "_rk"}, bus.o_rk, beat_of(exp_rk[exp_idx], exp_idx));
      chk({name, "_last"}, 128'(bus.o_last), 128'(exp_idx == 0));
      if (exp_idx == abort_idx) begin
        rst = 1'b1;
        #1;
        chk({name, "_reset_outs"}, {bus.o_rk, 4'(bus.o_rk_idx), bus.o_rk_valid, bus.o_busy,
                                    bus.o_last, bus.o_done}, '0);
        tick();
        chk({name, "_reset_outs_edge"}, {bus.o_rk, 4'(bus.o_rk_idx), bus.o_rk_valid,
                                         bus.o_busy, bus.o_last, bus.o_done}, '0);
        rst = 1'b0;
        bus.i_rk_ready = 1'b0;
        tick();
        return;
      end
      bus.i_start = (busy_starts && cyc == 15) ? 1'b1 : 1'b0;
      bus.i_rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = bus.i_rk_ready;
      got_rk[exp_idx] = bus.o_rk;
      prev_rk = bus.o_rk;
      prev_idx = bus.o_rk_idx;
      prev_stall = !hs;
      tick();
      guard++;
      if (hs) begin
        beats++;
        if (exp_idx == 0) break;
        exp_idx--;
      end
    end
    bus.i_start = 1'b0;
    bus.i_rk_ready = 1'b0;
    chk({name, "_beats"}, 128'(beats), 128'd11);
    chk({name, "_done"}, 128'(bus.o_done), 128'd1);
    chk({name, "_valid_off"}, 128'(bus.o_rk_valid), 128'd0);
    if (timing) chk({name, "_done_cycle"}, 128'(cyc), 128'd22);
    tick();
    chk({name, "_done_pulse"}, 128'(bus.o_done), 128'd0);
    chk({name, "_idle"}, 128'(bus.o_busy), 128'd0);
    repeat (3) tick();
    chk({name, "_no_restart"}, 128'(bus.o_busy), 128'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_key = '0;
    bus.i_rk_ready = 1'b0;
    init_sbox();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rk", bus.o_rk, '0);
    chk("rst_idx", 128'(bus.o_rk_idx), '0);
    chk("rst_valid", 128'(bus.o_rk_valid), '0);
    chk("rst_busy", 128'(bus.o_busy), '0);
    chk("rst_last", 128'(bus.o_last), '0);
    chk("rst_done", 128'(bus.o_done), '0);
    rst = 1'b0;
    bus.i_rk_ready = 1'b1;
    tick();
    chk("idle_ready_ignored", 128'({bus.o_rk_valid, bus.o_busy}), '0);
    bus.i_rk_ready = 1'b0;

    run_stream(FipsKey, 1'b0, 1'b1, 1'b0, -1, "fips");
    chk("fips_lit_rk10", got_rk[10], FipsRk10);
    chk("fips_lit_rk1", got_rk[1], beat_of(FipsRk1, 1));
    chk("fips_lit_rk0", got_rk[0], FipsKey);

    run_stream('0, 1'b0, 1'b1, 1'b0, -1, "zero");
    chk("zero_lit_rk10", got_rk[10], ZeroRk10);
    chk("zero_lit_rk0", got_rk[0], '0);

    for (int n = 0; n < 4; n++) begin
      run_stream({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 1'b0, -1, "bp");
    end

    run_stream(FipsKey, 1'b0, 1'b1, 1'b1, -1, "busy");
    chk("busy_lit_rk10", got_rk[10], FipsRk10);

    run_stream({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b0, 6, "abort");
    run_stream({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 1'b0, -1, "post");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_dec_key_stream.md
Name: aes_dec_key_stream

Overview:
Iterative AES-128 key expander for the decrypt path of the AES-GCM datapath.
- Accepts a 128-bit cipher key and expands it one round per cycle into an internal 11-entry round-key store.
- Streams the round keys out in reverse order (round 10 first, round 0 last) over a valid/ready handshake, which is the order the inverse cipher consumes them.
- Complements the forward key-schedule generators, which emit keys in encrypt order.

Parameters:
- NR, 10, number of AES rounds; only 10 (AES-128) is supported. Any other value is an elaboration error.

Ports:
- clk  input  1  single clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_start  input  1  one-cycle request to expand i_key; sampled only in IDLE.
- i_key  input  128 [0:127]  cipher key; byte 0 is bits [0:7]; sampled with i_start.
- o_busy  output  1  high in EXPAND and STREAM.
- o_rk  output  128 [0:127]  current round key.
- o_rk_idx  output  4  round number of o_rk, counting 10 down to 0.
- o_rk_valid  output  1  o_rk and o_rk_idx are valid.
- i_rk_ready  input  1  consumer accepts the beat when o_rk_valid and i_rk_ready are both high.
- o_last  output  1  high together with o_rk_valid when o_rk_idx == 0.
- o_done  output  1  one-cycle pulse after the round-0 handshake.

Behaviour:
- Reset: asynchronous, active-high, on i_reset; all outputs are held at 0 while i_reset is asserted.
  - State returns to IDLE and the round-key store is cleared to 0.
  - Reset in any state aborts the operation immediately; no partial stream resumes.
- States:
  - IDLE: o_busy=0. If i_start=1, load rk[0]=i_key, set rcon=0x01, set round counter r=1, go to EXPAND. Otherwise stay.
  - EXPAND: each cycle, rk[r] = next(rk[r-1], rcon).
    - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
    - rcon updates by GF(2^8) doubling (xtime, poly 0x11B): 01,02,04,08,10,20,40,80,1B,36.
    - When r == 10 is written, go to STREAM with idx=10.
    - EXPAND lasts exactly 10 cycles.
  - STREAM: o_rk_valid=1, o_rk=rk[idx], o_rk_idx=idx.
    - On handshake: if idx == 0, go to DONE; otherwise idx decrements.
    - Without a handshake, o_rk and o_rk_idx hold stable. Valid never drops before the handshake.
  - DONE: o_done=1 for one cycle, then go to IDLE.
- Latency: with i_start at cycle 0, o_rk_valid first rises at cycle 11. With i_rk_ready held high, the stream runs cycles 11–21, o_done is high at cycle 22, and the next i_start is accepted at cycle 23.
- i_start while o_busy=1 is ignored; the operation in progress is unaffected.
- i_key is captured only on the start cycle; changing it later has no effect.
- i_rk_ready high while o_rk_valid is low is ignored.

Optional Feature:
- Macro: AES_EQ_INV_KEY_EN.
- Defined: in STREAM, beats with idx 9..1 output InvMixColumns(rk[idx]), column-wise over the four 32-bit words. Beats with idx 10 and 0 are output unmodified. This gives the equivalent-inverse-cipher key schedule.
  - InvMixColumns is combinational on the output mux; latency is unchanged.
- Undefined: all beats output the raw rk[idx].

Decomposition:
- Package aes_pkg:
  - typedef block_t = logic [0:127]; typedef word_t = logic [0:31].
  - SBOX constant array and sub_word function.
  - RCON_INIT constant and xtime function.
  - inv_mix_column function, used only under AES_EQ_INV_KEY_EN.
  - State enum {IDLE, EXPAND, STREAM, DONE}.
- Sub-module aes_key_round: combinational next round key from (prev block_t, rcon byte), containing 4 S-box instances.
- The top level holds the FSM, counters, the 11x128 store and the output mux.

Test Plan:
- Expansion and order: key 2b7e151628aed2a6abf7158809cf4f3c, ready=1.
  - First beat at cycle 11: idx=10, rk=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Beat idx=1: rk=a0fafe1788542cb123a339392a6c7605.
  - Last beat: idx=0, o_last=1, rk=the input key. o_done=1 at cycle 22.
- Zero key 000…0: first beat rk=b4ef5bcb3e92e21123e951cf6f8f188e, idx=10; idx=0 beat is all-zero.
- Backpressure: toggle ready randomly.
  - Exactly 11 beats are accepted, with indices 10..0 and no repeat or skip.
  - o_rk is stable while valid&&!ready.
- Busy start: pulse i_start with a different key at cycles 3 and 15. The stream is identical to the first-key result, and no second expansion occurs.
- Reset mid-STREAM at idx=6: all outputs are 0 in the next sampled cycle. A new start then yields a full 11-beat stream from idx=10.
- AES_EQ_INV_KEY_EN defined, FIPS key:
  - Beats idx 10 and 0 match the raw keys.
  - Beat idx 1 equals InvMixColumns(a0fafe17…7605), checked against the reference model.
